// File: rtl/pll_drp_if.sv
// pll_drp_if: DRP access bus plus busy/addr_err status between a DRP master and pll_drp_ctrl.
interface pll_drp_if;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;
    logic        busy;
    logic        addr_err;
    modport master (output daddr, den, dwe, di, input dout, drdy, busy, addr_err);
    modport slave  (input daddr, den, dwe, di, output dout, drdy, busy, addr_err);
endinterface

// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl: DRP slave holding PLL/MMCM divider registers with decoded, apply-gated outputs.
// Define PLL_DRP_AUX_REGS_EN to add LockReg1-3, PowerReg and FiltReg1/2 as plain storage.
module pll_drp_ctrl #(
    parameter int NUM_CLKOUT     = 6,
    parameter int DRDY_LATENCY   = 1,
    parameter int DEFAULT_DIVIDE = 1,
    parameter int DEFAULT_MULT   = 5,
    parameter int DEFAULT_DIVCLK = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    pll_drp_if.slave                drp,
    input  logic                    apply_i,
    output logic [8*NUM_CLKOUT-1:0] cfg_divide_o,
    output logic [7:0]              cfg_mult_o,
    output logic [7:0]              cfg_divclk_o,
    output logic                    cfg_update_o
);
`ifdef PLL_DRP_AUX_REGS_EN
    localparam int NSLOT = 23;
`else
    localparam int NSLOT = 17;
`endif
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [15:0]             regs_q [NSLOT];
    logic [15:0]             dout_q;
    logic                    err_q, hit, acc, drdy;
    logic [4:0]              slot;
    logic [8*NUM_CLKOUT-1:0] div_sh, cfg_divide_q;
    logic [7:0]              mult_sh, divclk_sh, cfg_mult_q, cfg_divclk_q;
    logic                    cfg_update_q;

    function automatic logic [15:0] enc1(input int d);
        return {4'd0, 6'((d + 1) / 2), 6'(d / 2)};
    endfunction

    function automatic logic [15:0] enc2(input int d);
        return {8'd0, 1'(d % 2), d == 1, 6'd0};
    endfunction

    // Slots: 2n/2n+1 channel n, 14/15 feedback, 16 DivReg, 17.. auxiliary storage
    function automatic logic [15:0] def_val(input int i);
        if (i < 14) return i % 2 == 0 ? enc1(DEFAULT_DIVIDE) : enc2(DEFAULT_DIVIDE);
        if (i == 14) return enc1(DEFAULT_MULT);
        if (i == 15) return enc2(DEFAULT_MULT);
        if (i == 16) return {2'd0, DEFAULT_DIVCLK == 1, 1'(DEFAULT_DIVCLK % 2), enc1(DEFAULT_DIVCLK)[11:0]};
        return 16'h0;
    endfunction

    function automatic logic [5:0] ch_base(input int n);
        return n < 5 ? 6'(4 + n) : n == 5 ? 6'd3 : 6'd9;
    endfunction

    // A zero HIGH/LOW field counts as 64
    function automatic logic [7:0] dec(input logic nc, input logic [5:0] h, input logic [5:0] l);
        return nc ? 8'd1 : {1'b0, h == 6'd0, h} + {1'b0, l == 6'd0, l};
    endfunction

    always_comb begin
        slot = '0;
        hit  = 1'b0;
        for (int n = 0; n < NUM_CLKOUT; n++)
            if (drp.daddr[6:1] == ch_base(n)) begin
                slot = {n[3:0], drp.daddr[0]};
                hit  = 1'b1;
            end
        if (drp.daddr[6:1] == 6'h0A) begin
            slot = {4'd7, drp.daddr[0]};
            hit  = 1'b1;
        end
        if (drp.daddr == 7'h16) begin
            slot = 5'd16;
            hit  = 1'b1;
        end
`ifdef PLL_DRP_AUX_REGS_EN
        if (drp.daddr inside {7'h18, 7'h19, 7'h1A}) begin
            slot = drp.daddr[4:0] - 5'd7;
            hit  = 1'b1;
        end
        if (drp.daddr == 7'h28) begin
            slot = 5'd20;
            hit  = 1'b1;
        end
        if (drp.daddr[6:1] == 6'h27) begin
            slot = 5'd21 + {4'd0, drp.daddr[0]};
            hit  = 1'b1;
        end
`endif
    end

    for (genvar g = 0; g < NUM_CLKOUT; g++)
        assign div_sh[8*g +: 8] = dec(regs_q[2*g+1][6], regs_q[2*g][11:6], regs_q[2*g][5:0]);
    assign mult_sh   = dec(regs_q[15][6], regs_q[14][11:6], regs_q[14][5:0]);
    assign divclk_sh = dec(regs_q[16][13], regs_q[16][11:6], regs_q[16][5:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc     = 1'b0;
        if (state_q == S_IDLE) begin
            acc = drp.den;
            if (drp.den) begin
                state_d = S_WAIT;
                cnt_d   = 3'(DRDY_LATENCY - 1);
            end
        end else if (cnt_q == 3'd0) begin
            state_d = S_IDLE;
        end else begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dout_q       <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NSLOT; i++) regs_q[5'(i)] <= def_val(i);
            cfg_divide_q <= {NUM_CLKOUT{8'(DEFAULT_DIVIDE)}};
            cfg_mult_q   <= 8'(DEFAULT_MULT);
            cfg_divclk_q <= 8'(DEFAULT_DIVCLK);
            cfg_update_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc) begin
                err_q <= !hit;
                if (drp.dwe && hit) regs_q[slot] <= drp.di;
                if (!drp.dwe) dout_q <= hit ? regs_q[slot] : 16'h0;
            end
            if (apply_i) begin
                cfg_divide_q <= div_sh;
                cfg_mult_q   <= mult_sh;
                cfg_divclk_q <= divclk_sh;
            end
            cfg_update_q <= apply_i && {div_sh, mult_sh, divclk_sh} != {cfg_divide_q, cfg_mult_q, cfg_divclk_q};
        end
    end

    assign drdy         = state_q == S_WAIT && cnt_q == 3'd0;
    assign drp.drdy     = drdy;
    assign drp.busy     = state_q == S_WAIT && cnt_q != 3'd0;
    assign drp.addr_err = drdy && err_q;
    assign drp.dout     = dout_q;
    assign cfg_divide_o = cfg_divide_q;
    assign cfg_mult_o   = cfg_mult_q;
    assign cfg_divclk_o = cfg_divclk_q;
    assign cfg_update_o = cfg_update_q;
endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb_pll_drp_ctrl: directed vectors, multi-cycle corner sequences and a randomized
// run against an address-indexed register model for pll_drp_ctrl (4 channels, latency 3).
module tb_pll_drp_ctrl;
    localparam int NC = 4;
    logic clk = 1'b0, rst = 1'b1, apply = 1'b0;
    logic [8*NC-1:0] cfg_divide;
    logic [7:0] cfg_mult, cfg_divclk;
    logic cfg_update;
    int total = 0, passed = 0;
    logic [15:0] rd, d, mreg [128], e_do;
    logic [6:0] a;
    logic er, we, drdy_seen;
    int lat, op;
    logic [8*NC-1:0] e_div;
    logic [7:0] e_mult, e_divclk;
    logic [8*NC+15:0] old_cfg;

    typedef struct {
        logic [6:0]  a;
        logic        we;
        logic [15:0] d;
        logic [15:0] rd;
        logic        er;
    } vec_t;
    vec_t tbl [18];

    pll_drp_if bus();

    pll_drp_ctrl #(.NUM_CLKOUT(NC), .DRDY_LATENCY(3), .DEFAULT_DIVIDE(5),
                   .DEFAULT_MULT(5), .DEFAULT_DIVCLK(1)) dut (
        .clk_i(clk), .rst_i(rst), .drp(bus), .apply_i(apply),
        .cfg_divide_o(cfg_divide), .cfg_mult_o(cfg_mult),
        .cfg_divclk_o(cfg_divclk), .cfg_update_o(cfg_update)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    // Called at a negedge; returns at a negedge with the slave idle again
    task automatic access(input logic [6:0] ad, input logic w, input logic [15:0] dat,
                          output logic [15:0] r, output logic e, output int l);
        bus.daddr = ad; bus.dwe = w; bus.di = dat; bus.den = 1'b1;
        @(negedge clk);
        bus.den = 1'b0;
        l = 1;
        while (!bus.drdy && l < 20) begin
            @(negedge clk);
            l++;
        end
        r = bus.dout;
        e = bus.addr_err;
        @(negedge clk);
    endtask

    task automatic apply_pulse();
        apply = 1'b1;
        @(negedge clk);
        apply = 1'b0;
    endtask

    function automatic bit mapped(input logic [6:0] ad);
        return (ad >= 7'h08 && ad <= 7'h0F) || (ad >= 7'h14 && ad <= 7'h16);
    endfunction

    function automatic int fdiv(input logic [15:0] r1, input logic nc);
        int h = int'(r1[11:6]);
        int l = int'(r1[5:0]);
        if (nc) return 1;
        return (h == 0 ? 64 : h) + (l == 0 ? 64 : l);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mreg[i] = 16'h0;
        for (int n = 0; n < NC; n++) begin
            mreg[8+2*n] = 16'h00C2;
            mreg[9+2*n] = 16'h0080;
        end
        mreg[7'h14] = 16'h00C2;
        mreg[7'h15] = 16'h0080;
        mreg[7'h16] = 16'h3040;
        e_div = {NC{8'd5}}; e_mult = 8'd5; e_divclk = 8'd1; e_do = 16'h0;
    endtask

    task automatic model_apply();
        for (int n = 0; n < NC; n++) e_div[8*n +: 8] = 8'(fdiv(mreg[8+2*n], mreg[9+2*n][6]));
        e_mult   = 8'(fdiv(mreg[7'h14], mreg[7'h15][6]));
        e_divclk = 8'(fdiv(mreg[7'h16], mreg[7'h16][13]));
    endtask

    initial begin
        tbl = '{
            '{7'h08, 1'b0, 16'h0000, 16'h00C2, 1'b0},
            '{7'h09, 1'b0, 16'h0000, 16'h0080, 1'b0},
            '{7'h0E, 1'b0, 16'h0000, 16'h00C2, 1'b0},
            '{7'h0F, 1'b0, 16'h0000, 16'h0080, 1'b0},
            '{7'h10, 1'b0, 16'h0000, 16'h0000, 1'b1},
            '{7'h10, 1'b1, 16'hBEEF, 16'h0000, 1'b1},
            '{7'h10, 1'b0, 16'h0000, 16'h0000, 1'b1},
            '{7'h06, 1'b0, 16'h0000, 16'h0000, 1'b1},
            '{7'h14, 1'b0, 16'h0000, 16'h00C2, 1'b0},
            '{7'h15, 1'b0, 16'h0000, 16'h0080, 1'b0},
            '{7'h16, 1'b0, 16'h0000, 16'h3040, 1'b0},
            '{7'h0A, 1'b1, 16'h0104, 16'h3040, 1'b0},
            '{7'h0A, 1'b0, 16'h0000, 16'h0104, 1'b0},
            '{7'h18, 1'b0, 16'h0000, 16'h0000, 1'b1},
            '{7'h0D, 1'b1, 16'hE0BF, 16'h0000, 1'b0},
            '{7'h0D, 1'b0, 16'h0000, 16'hE0BF, 1'b0},
            '{7'h12, 1'b0, 16'h0000, 16'h0000, 1'b1},
            '{7'h17, 1'b0, 16'h0000, 16'h0000, 1'b1}
        };
        bus.daddr = '0; bus.dwe = 1'b0; bus.di = '0; bus.den = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset dout", bus.dout, 16'h0);
        check("reset drdy/busy/err/upd", {bus.drdy, bus.busy, bus.addr_err, cfg_update}, 4'b0);
        check("reset cfg_divide", cfg_divide, {NC{8'd5}});
        check("reset cfg_mult/divclk", {cfg_mult, cfg_divclk}, {8'd5, 8'd1});
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) begin
            access(tbl[i].a, tbl[i].we, tbl[i].d, rd, er, lat);
            check($sformatf("vec%0d dout", i), rd, tbl[i].rd);
            check($sformatf("vec%0d addr_err", i), er, tbl[i].er);
            check($sformatf("vec%0d latency", i), lat, 3);
        end
        check("no apply yet cfg_divide", cfg_divide, {NC{8'd5}});

        apply = 1'b1;
        @(negedge clk);
        check("apply ch1 divide", cfg_divide[15:8], 8'd8);
        check("apply others", {cfg_divide[31:16], cfg_divide[7:0]}, {8'd5, 8'd5, 8'd5});
        check("apply update pulse", cfg_update, 1'b1);
        @(negedge clk);
        check("apply held no change", cfg_update, 1'b0);
        apply = 1'b0;
        @(negedge clk);
        check("update single pulse", cfg_update, 1'b0);

        // write and apply on the same edge: old value stays active
        bus.daddr = 7'h08; bus.dwe = 1'b1; bus.di = 16'h0041; bus.den = 1'b1; apply = 1'b1;
        @(negedge clk);
        bus.den = 1'b0; apply = 1'b0;
        check("same-cycle apply ch0", cfg_divide[7:0], 8'd5);
        check("same-cycle apply upd", cfg_update, 1'b0);
        repeat (4) @(negedge clk);
        apply_pulse();
        check("next apply ch0", cfg_divide[7:0], 8'd2);
        check("next apply upd", cfg_update, 1'b1);

        access(7'h0C, 1'b1, 16'h0000, rd, er, lat);
        apply_pulse();
        check("zero fields ch2", cfg_divide[23:16], 8'd128);
        access(7'h0D, 1'b1, 16'h0040, rd, er, lat);
        apply_pulse();
        check("no_count ch2", cfg_divide[23:16], 8'd1);

        // latency 3 with DEN during busy and during DRDY
        bus.daddr = 7'h08; bus.dwe = 1'b0; bus.den = 1'b1;
        @(negedge clk);
        check("t+1 busy/drdy", {bus.busy, bus.drdy}, 2'b10);
        bus.dwe = 1'b1; bus.di = 16'h1234;
        @(negedge clk);
        bus.den = 1'b0;
        check("t+2 busy/drdy", {bus.busy, bus.drdy}, 2'b10);
        @(negedge clk);
        check("t+3 busy/drdy", {bus.busy, bus.drdy}, 2'b01);
        check("t+3 dout", bus.dout, 16'h0041);
        bus.daddr = 7'h08; bus.dwe = 1'b1; bus.di = 16'h5678; bus.den = 1'b1;
        @(negedge clk);
        bus.den = 1'b0;
        check("t+4 busy/drdy", {bus.busy, bus.drdy}, 2'b00);
        @(negedge clk);
        access(7'h08, 1'b0, 16'h0, rd, er, lat);
        check("ignored writes", rd, 16'h0041);

        // reset during WAIT
        bus.daddr = 7'h0A; bus.dwe = 1'b0; bus.den = 1'b1;
        @(negedge clk);
        bus.den = 1'b0;
        check("pre-reset busy", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1 check("async reset busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drdy_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drdy_seen |= bus.drdy;
        end
        check("aborted access drdy", drdy_seen, 1'b0);
        check("post-reset cfg_divide", cfg_divide, {NC{8'd5}});
        access(7'h08, 1'b0, 16'h0, rd, er, lat);
        check("post-reset 0x08", rd, 16'h00C2);
        access(7'h0A, 1'b0, 16'h0, rd, er, lat);
        check("post-reset 0x0A", rd, 16'h00C2);
        access(7'h0C, 1'b0, 16'h0, rd, er, lat);
        check("post-reset 0x0C", rd, 16'h00C2);
        access(7'h0D, 1'b0, 16'h0, rd, er, lat);
        check("post-reset 0x0D", rd, 16'h0080);

        model_reset();
        e_do = 16'h0080;
        for (int k = 0; k < 250; k++) begin
            op = int'($urandom_range(0, 9));
            a  = $urandom_range(0, 1) == 1 ? 7'($urandom_range(0, 127)) : 7'($urandom_range(6, 23));
            d  = 16'($urandom);
            if (op < 2) begin
                old_cfg = {e_div, e_mult, e_divclk};
                model_apply();
                apply_pulse();
                check($sformatf("rnd%0d cfg", k), {cfg_divide, cfg_mult, cfg_divclk}, {e_div, e_mult, e_divclk});
                check($sformatf("rnd%0d update", k), cfg_update, old_cfg != {e_div, e_mult, e_divclk});
            end else begin
                we = op < 6;
                access(a, we, d, rd, er, lat);
                if (!we) e_do = mapped(a) ? mreg[a] : 16'h0;
                else if (mapped(a)) mreg[a] = d;
                check($sformatf("rnd%0d dout a=%0h", k, a), rd, e_do);
                check($sformatf("rnd%0d addr_err a=%0h", k, a), er, !mapped(a));
                check($sformatf("rnd%0d latency", k), lat, 3);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pll_drp_ctrl.md
Name: pll_drp_ctrl

Overview:
- Parametrised dynamic-reconfiguration-port (DRP) slave for the simulated 7-series PLL/MMCM clocking models.
- Holds the ClkReg1/ClkReg2 register pairs for NUM_CLKOUT output channels plus the feedback and DivReg registers.
- Provides a latency-configurable DRDY handshake with busy and address-error detection.
- Decodes HIGH_TIME/LOW_TIME fields into shadowed per-channel divide values; these reach the frequency generators only when an apply request occurs.

Parameters:
- NUM_CLKOUT, 6, number of CLKOUT channels, legal range 1-7.
- DRDY_LATENCY, 1, cycles from the accepted DEN to DRDY, legal range 1-8.
- DEFAULT_DIVIDE, 1, reset divide for every CLKOUT channel, legal range 1-128.
- DEFAULT_MULT, 5, reset CLKFBOUT multiplier, legal range 2-64.
- DEFAULT_DIVCLK, 1, reset DIVCLK divide, legal range 1-56.

Ports:
- DCLK  in  1  DRP clock, the only clock.
- RST  in  1  asynchronous, active-high reset.
- DADDR  in  7  register address.
- DEN  in  1  one-cycle access strobe.
- DWE  in  1  write enable, sampled with DEN.
- DI  in  16  write data.
- DO  out  16  read data, valid while DRDY is high.
- DRDY  out  1  one-cycle completion pulse.
- apply  in  1  copy decoded shadow values to the active outputs; the system ties it to the PLL reset.
- cfg_divide  out  8*NUM_CLKOUT  active divide per channel; channel n occupies bits [8n+7:8n].
- cfg_mult  out  8  active feedback multiplier.
- cfg_divclk  out  8  active input divider.
- cfg_update  out  1  one-cycle pulse after the active values change.
- busy  out  1  high from the accepted DEN until DRDY.
- addr_err  out  1  one-cycle pulse alongside DRDY for an unmapped address.

Behaviour:
- Reset (asynchronous, active-high):
  - DO=0, DRDY=0, busy=0, addr_err=0, cfg_update=0.
  - Registers are encoded from their DEFAULT_* parameter as follows:
    - HIGH_TIME=ceil(D/2).
    - LOW_TIME=floor(D/2).
    - EDGE=D odd.
    - NO_COUNT=(D==1).
  - The active outputs equal the DEFAULT_* values.
- Address map:
  - Channels 0-4: ClkReg1 at 0x08+2n, ClkReg2 at 0x09+2n.
  - Channel 5: 0x06/0x07.
  - Channel 6: 0x12/0x13.
  - Feedback: 0x14/0x15.
  - DivReg: 0x16.
  - Channels at or above NUM_CLKOUT are unmapped.
- Register fields:
  - ClkReg1: [5:0] LOW_TIME, [11:6] HIGH_TIME, [15:13] PHASE_MUX.
  - ClkReg2: [5:0] DELAY_TIME, [6] NO_COUNT, [7] EDGE.
  - DivReg: [5:0] LOW, [11:6] HIGH, [12] EDGE, [13] NO_COUNT.
  - All bits are stored and read back verbatim.
- Divide decode:
  - divide = NO_COUNT ? 1 : H+L, where a field value of 0 means 64.
  - The result is 8 bits wide, maximum 128.
  - The decode is combinational from the registers into the shadow values.
- Handshake, FSM IDLE -> WAIT -> IDLE:
  - In IDLE, DEN=1 accepts the access:
    - A write updates the register on that edge.
    - A read captures the register into DO.
    - busy is set and the counter is loaded with DRDY_LATENCY-1.
  - In WAIT, the counter decrements. At 0, DRDY=1 for one cycle, busy drops, and the FSM returns to IDLE.
  - With DRDY_LATENCY=1, DRDY rises on the cycle after DEN.
  - DEN while busy=1 is ignored: no register change and no extra DRDY. DEN in the same cycle DRDY is high is also ignored.
  - DO holds its last value outside DRDY. A write leaves DO unchanged.
- Unmapped address:
  - A write is discarded.
  - A read returns 0x0000.
  - DRDY is still produced, and addr_err pulses in the same cycle.
- Apply:
  - apply=1 on an edge copies the shadow values to cfg_divide, cfg_mult and cfg_divclk.
  - cfg_update pulses on the next cycle, but only if some value changed.
  - Holding apply high tracks writes continuously, with one cycle of latency.
  - A write and apply in the same cycle: the new value reaches the active outputs on the following apply cycle.
- Asynchronous RST mid-access aborts the access: no DRDY is produced and the registers return to their defaults.

Optional Feature:
- Macro PLL_DRP_AUX_REGS_EN.
- When defined, LockReg1-3 (0x18-0x1A), PowerReg (0x28) and FiltReg1/2 (0x4E/0x4F) are implemented as plain read/write storage reset to 0x0000 with no decode.
- When undefined, these addresses are unmapped: reads return 0, writes are discarded, addr_err pulses.

Test Plan:
- Reset with DEFAULT_DIVIDE=5 -> read 0x08 returns 0x00C2 (HIGH=3, LOW=2), read 0x09 returns 0x0080 (EDGE=1); cfg_divide channel 0 = 5.
- Write 0x0A=0x0104 (HIGH=4, LOW=4), then pulse apply -> cfg_divide channel 1 = 8; cfg_update pulses once, one cycle after apply.
- DRDY_LATENCY=3: DEN read at cycle t -> DRDY high only at t+3; busy high t+1..t+2; a second DEN at t+1 produces no effect.
- NUM_CLKOUT=4: read 0x10 -> DO=0x0000 with addr_err and DRDY in the same cycle; write 0x10 then read back still returns 0.
- Write ClkReg1=0x0000 with NO_COUNT=0, then apply -> divide=128. Set NO_COUNT=1, then apply -> divide=1.
- Assert RST during WAIT -> DRDY never asserts, busy=0, all registers read back as defaults afterwards.
